// File: rtl/student_fir_pkg.sv
// Shared types and rescaling helper for the FIR output path.
// round_shift_sat is reused by later rescaling stages.
package student_fir_pkg;

  localparam int DATA_SIZE_FIR_OUT = 32;
  localparam int DATA_OUT_W = 16;
  localparam int SUM_W = DATA_SIZE_FIR_OUT + 1;

  typedef logic signed [DATA_OUT_W-1:0] sample_t;

  typedef struct packed {
    sample_t sample;
    logic    sat;
  } scaled_t;

  localparam logic signed [SUM_W:0] SAMPLE_MAX =
    (SUM_W+1)'(2**(DATA_OUT_W-1) - 1);
  localparam logic signed [SUM_W:0] SAMPLE_MIN = ~SAMPLE_MAX;

  // One guard bit above the sum keeps the rounding bias from wrapping.
  function automatic scaled_t round_shift_sat(
    input logic signed [SUM_W-1:0] sum,
    input int                      shift
  );
    logic signed [SUM_W:0] ext;
    logic signed [SUM_W:0] bias;
    logic signed [SUM_W:0] r;
    scaled_t               res;
    ext = {sum[SUM_W-1], sum};
    bias = '0;
    if (shift > 0) begin
      bias = (SUM_W+1)'(1) << (shift - 1);
    end
    r = (ext + bias) >>> shift;
    res.sat = 1'b0;
    if (r > SAMPLE_MAX) begin
      res.sample = sample_t'(SAMPLE_MAX);
      res.sat = 1'b1;
    end else if (r < SAMPLE_MIN) begin
      res.sample = sample_t'(SAMPLE_MIN);
      res.sat = 1'b1;
    end else begin
      res.sample = r[DATA_OUT_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/student_sync_fifo.sv
// Show-ahead synchronous FIFO with separate occupancy counter.
// A push while full is accepted only when a pop frees the slot.
module student_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/student_sum_sink.sv
// Adder-output sink: round/shift/saturate stage, output FIFO,
// sticky overflow and saturation flags.
module student_sum_sink #(
  parameter int DATA_SIZE_FIR_OUT = student_fir_pkg::DATA_SIZE_FIR_OUT,
  parameter int DATA_OUT_W        = student_fir_pkg::DATA_OUT_W,
  parameter int SHIFT             = 15,
  parameter int FIFO_DEPTH        = 4
) (
  input  logic                            clk,
  input  logic                            rst_ni,
  input  logic                            valid_strobe_in,
  input  logic [DATA_SIZE_FIR_OUT:0]      sum_in,
  output logic [DATA_OUT_W-1:0]           data_o,
  output logic                            valid_o,
  input  logic                            ready_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count_o,
  output logic                            overflow_o,
  output logic                            sat_o,
  input  logic                            clear_i
);

  import student_fir_pkg::*;

  scaled_t               scaled;
  logic                  stage_valid;
  logic                  stage_sat;
  logic [DATA_OUT_W-1:0] stage_data;
  logic                  pop;
  logic                  full;
  logic                  empty;
  logic                  accept;
  logic                  ovf_event;
  logic                  sat_event;

  assign scaled = round_shift_sat(sum_in, SHIFT);

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_valid <= 1'b0;
      stage_sat   <= 1'b0;
      stage_data  <= '0;
    end else begin
      stage_valid <= valid_strobe_in;
      if (valid_strobe_in) begin
        stage_data <= scaled.sample;
        stage_sat  <= scaled.sat;
      end
    end
  end

  assign valid_o   = ~empty;
  assign pop       = valid_o & ready_i;
  assign accept    = stage_valid & (~full | pop);
  assign ovf_event = stage_valid & ~accept;
  assign sat_event = accept & stage_sat;

  // A new event in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      overflow_o <= 1'b0;
      sat_o      <= 1'b0;
    end else begin
      overflow_o <= ovf_event | (overflow_o & ~clear_i);
      sat_o      <= sat_event | (sat_o & ~clear_i);
    end
  end

  student_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_OUT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_ni),
    .push  (stage_valid),
    .wdata (stage_data),
    .pop   (pop),
    .rdata (data_o),
    .full  (full),
    .empty (empty),
    .count (count_o)
  );

endmodule

// File: tb/tb_student_sum_sink.sv
// Self-checking bench for student_sum_sink with a queue-based
// reference model, directed scenarios and a randomized phase.
module tb_student_sum_sink;

  localparam int FW    = 32;
  localparam int OW    = 16;
  localparam int SHIFT = 15;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          valid_strobe_in;
  logic [FW:0]   sum_in;
  logic [OW-1:0] data_o;
  logic          valid_o;
  logic          ready_i;
  logic [CW-1:0] count_o;
  logic          overflow_o;
  logic          sat_o;
  logic          clear_i;

  int n_checks = 0;
  int n_fail   = 0;

  logic [OW-1:0] mq [$];
  bit            m_sv;
  bit            m_ss;
  logic [OW-1:0] m_sd;
  bit            m_ovf;
  bit            m_sat;

  student_sum_sink #(
    .DATA_SIZE_FIR_OUT (FW),
    .DATA_OUT_W        (OW),
    .SHIFT             (SHIFT),
    .FIFO_DEPTH        (DEPTH)
  ) dut (
    .clk             (clk),
    .rst_ni          (rst_ni),
    .valid_strobe_in (valid_strobe_in),
    .sum_in          (sum_in),
    .data_o          (data_o),
    .valid_o         (valid_o),
    .ready_i         (ready_i),
    .count_o         (count_o),
    .overflow_o      (overflow_o),
    .sat_o           (sat_o),
    .clear_i         (clear_i)
  );

  always #5 clk = ~clk;

  function automatic logic [OW-1:0] ref_scale(
    input longint s, output bit sat);
    longint v;
    v = s;
    if (SHIFT > 0) v = v + (longint'(1) <<< (SHIFT - 1));
    v = v >>> SHIFT;
    sat = 1'b0;
    if (v > 32767) begin
      v = 32767;
      sat = 1'b1;
    end else if (v < -32768) begin
      v = -32768;
      sat = 1'b1;
    end
    return v[OW-1:0];
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [OW-1:0] ed;
    ed = (mq.size() > 0) ? mq[0] : '0;
    chk({tag, "_valid"}, 32'(valid_o), 32'(mq.size() > 0));
    chk({tag, "_data"}, 32'(data_o), 32'(ed));
    chk({tag, "_count"}, 32'(count_o), 32'(mq.size()));
    chk({tag, "_ovf"}, 32'(overflow_o), 32'(m_ovf));
    chk({tag, "_sat"}, 32'(sat_o), 32'(m_sat));
  endtask

  task automatic model_reset();
    mq.delete();
    m_sv  = 1'b0;
    m_ss  = 1'b0;
    m_sd  = '0;
    m_ovf = 1'b0;
    m_sat = 1'b0;
  endtask

  task automatic step(input string tag, input bit s,
                      input longint sum, input bit rdy,
                      input bit clr);
    bit pop;
    bit acc;
    bit ovf_ev;
    bit sat_ev;
    @(negedge clk);
    valid_strobe_in = s;
    sum_in  = sum[FW:0];
    ready_i = rdy;
    clear_i = clr;
    @(posedge clk);
    pop    = (mq.size() > 0) && rdy;
    acc    = m_sv && ((mq.size() < DEPTH) || pop);
    ovf_ev = m_sv && !acc;
    sat_ev = acc && m_ss;
    if (pop) void'(mq.pop_front());
    if (acc) mq.push_back(m_sd);
    m_ovf = ovf_ev ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_sat = sat_ev ? 1'b1 : (clr ? 1'b0 : m_sat);
    m_sv = s;
    if (s) m_sd = ref_scale(sum, m_ss);
    #1;
    check_model(tag);
  endtask

  task automatic idle(input string tag, input bit rdy);
    step(tag, 1'b0, 0, rdy, 1'b0);
  endtask

  longint rnd_v [5] = '{32768, 16384, 16383, -16384, -16385};
  logic [15:0] rnd_e [5] = '{16'h0001, 16'h0001, 16'h0000,
                              16'h0000, 16'hFFFF};

  initial begin
    longint s;
    rst_ni = 1'b0;
    valid_strobe_in = 1'b0;
    sum_in  = '0;
    ready_i = 1'b0;
    clear_i = 1'b0;
    model_reset();
    #1;
    check_model("reset");
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b1;

    for (int i = 0; i < 5; i++) begin
      step("rnd_strobe", 1'b1, rnd_v[i], 1'b1, 1'b0);
      chk("rnd_lat1", 32'(valid_o), 32'(0));
      idle("rnd_wait", 1'b1);
      chk("rnd_value", 32'(data_o), 32'(rnd_e[i]));
      chk("rnd_nosat", 32'(sat_o), 32'(0));
      idle("rnd_pop", 1'b1);
    end

    step("sat_hi", 1'b1, longint'(1) <<< 31, 1'b1, 1'b0);
    step("sat_lo", 1'b1, -(longint'(1) <<< 31), 1'b1, 1'b0);
    chk("sat_hi_val", 32'(data_o), 32'h7FFF);
    chk("sat_flag", 32'(sat_o), 32'(1));
    idle("sat_w", 1'b1);
    chk("sat_lo_val", 32'(data_o), 32'h8000);
    step("sat_clr", 1'b0, 0, 1'b1, 1'b1);
    chk("sat_cleared", 32'(sat_o), 32'(0));

    for (int i = 1; i <= 5; i++) begin
      step("ovf_fill", 1'b1, longint'(i) <<< 15, 1'b0, 1'b0);
    end
    idle("ovf_last", 1'b0);
    chk("ovf_count", 32'(count_o), 32'(4));
    chk("ovf_flag", 32'(overflow_o), 32'(1));
    for (int i = 1; i <= 4; i++) begin
      chk("ovf_order", 32'(data_o), 32'(i));
      idle("ovf_drain", 1'b1);
    end
    chk("ovf_empty_cnt", 32'(count_o), 32'(0));
    chk("ovf_empty_vld", 32'(valid_o), 32'(0));
    step("ovf_clr", 1'b0, 0, 1'b1, 1'b1);
    chk("ovf_cleared", 32'(overflow_o), 32'(0));

    for (int i = 1; i <= 4; i++) begin
      step("fp_fill", 1'b1, longint'(i) <<< 15, 1'b0, 1'b0);
    end
    idle("fp_last", 1'b0);
    chk("fp_full", 32'(count_o), 32'(4));
    step("fp_strobe", 1'b1, longint'(9) <<< 15, 1'b0, 1'b0);
    idle("fp_pushpop", 1'b1);
    chk("fp_count", 32'(count_o), 32'(4));
    chk("fp_noovf", 32'(overflow_o), 32'(0));
    chk("fp_head", 32'(data_o), 32'(2));
    for (int i = 0; i < 4; i++) idle("fp_drain", 1'b1);
    chk("fp_empty", 32'(valid_o), 32'(0));

    begin
      int vcnt;
      vcnt = 0;
      for (int i = 0; i < 18; i++) begin
        if (i < 16) begin
          step("bb", 1'b1, longint'(i) <<< 15, 1'b1, 1'b0);
        end else begin
          idle("bb_tail", 1'b1);
        end
        if (valid_o) vcnt++;
        chk("bb_cnt_le1", 32'(count_o <= 1), 32'(1));
      end
      chk("bb_valid_cycles", 32'(vcnt), 32'(16));
    end

    for (int i = 1; i <= 4; i++) begin
      step("rst_fill", 1'b1, longint'(i) <<< 15, 1'b0, 1'b0);
    end
    chk("rst_pre_cnt", 32'(count_o), 32'(3));
    #2;
    rst_ni = 1'b0;
    #1;
    model_reset();
    check_model("rst_async");
    @(negedge clk);
    valid_strobe_in = 1'b0;
    ready_i = 1'b1;
    @(negedge clk);
    rst_ni = 1'b1;
    idle("rst_stale1", 1'b1);
    idle("rst_stale2", 1'b1);
    chk("rst_nostale", 32'(valid_o), 32'(0));
    step("rst_new", 1'b1, longint'(7) <<< 15, 1'b1, 1'b0);
    idle("rst_new_w", 1'b1);
    chk("rst_new_val", 32'(data_o), 32'(7));

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        s = longint'($signed({$urandom, $urandom})) >>> 31;
      end else begin
        s = longint'($urandom_range(0, 1 << 21)) - (1 << 20);
      end
      step("rand", $urandom_range(0, 9) < 7, s,
           $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
